// File: rtl/cfg_cmd_master.sv
// Turns {4'hA,addr}+data byte pairs into held config-bus writes via a small FIFO; c_valid rises two cycles after the data strobe.
// Writes wait indefinitely for c_ready; a packet arriving with the FIFO full and no pop is dropped and flagged.
module cfg_cmd_master #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       c_valid,
   output logic [3:0] c_addr,
   output logic [7:0] c_data,
   input  logic       c_ready,
   input  logic       err_clr,
   output logic       err_hdr,
   output logic       err_ovf,
   output logic       err_tmo,
   output logic       busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [3:0]      addr_q, addr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [11:0]     mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic            c_valid_q, c_valid_d;
   logic [3:0]      c_addr_q, c_addr_d;
   logic [7:0]      c_data_q, c_data_d;
   logic            err_hdr_q, err_hdr_d, err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d;

   logic wr_req, hdr_evt, tmo_evt, ovf_evt, push, pop, fifo_empty, fifo_full;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wr_req  = 1'b0;
      hdr_evt = 1'b0;
      tmo_evt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data[7:4] == 4'hA) begin
                  addr_d  = rx_data[3:0];
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  hdr_evt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            // A data byte arriving on the final window cycle still wins over the timeout.
            if (rx_valid) begin
               wr_req  = 1'b1;
               state_d = S_IDLE;
            end else if (cnt_q == TMO_LAST) begin
               tmo_evt = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign pop        = !fifo_empty && (!c_valid_q || c_ready);
   assign push       = wr_req && (!fifo_full || pop);
   assign ovf_evt    = wr_req && fifo_full && !pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      c_valid_d = c_valid_q;
      c_addr_d  = c_addr_q;
      c_data_d  = c_data_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (pop && !push) count_d = count_q - (PW+1)'(1);
      if (pop) begin
         c_valid_d              = 1'b1;
         {c_addr_d, c_data_d}   = mem_q[rd_ptr_q];
      end else if (c_valid_q && c_ready) begin
         c_valid_d = 1'b0;
      end
      err_hdr_d = hdr_evt | (err_hdr_q & ~err_clr);
      err_ovf_d = ovf_evt | (err_ovf_q & ~err_clr);
      err_tmo_d = tmo_evt | (err_tmo_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {addr_q, rx_data};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         c_valid_q <= 1'b0;
         c_addr_q  <= '0;
         c_data_q  <= '0;
         err_hdr_q <= 1'b0;
         err_ovf_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         c_valid_q <= c_valid_d;
         c_addr_q  <= c_addr_d;
         c_data_q  <= c_data_d;
         err_hdr_q <= err_hdr_d;
         err_ovf_q <= err_ovf_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   assign c_valid = c_valid_q;
   assign c_addr  = c_addr_q;
   assign c_data  = c_data_q;
   assign err_hdr = err_hdr_q;
   assign err_ovf = err_ovf_q;
   assign err_tmo = err_tmo_q;
   assign busy    = (state_q != S_IDLE) | !fifo_empty | c_valid_q;

endmodule

// File: tb/tb_cfg_cmd_master.sv
// Random and directed byte streams against a queue-level model of the command bridge.
module tb_cfg_cmd_master;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       c_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic       c_valid, err_hdr, err_ovf, err_tmo, busy;
   logic [3:0] c_addr;
   logic [7:0] c_data;

   always #5 clk = ~clk;

   cfg_cmd_master #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
      .err_clr(err_clr), .err_hdr(err_hdr), .err_ovf(err_ovf), .err_tmo(err_tmo),
      .busy(busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // Reference: a pending header with an idle-cycle age, a queue of parsed writes,
   // and one presented write.
   bit          m_pend;
   logic [3:0]  m_paddr;
   int          m_since;
   logic [11:0] m_fifo [$];
   bit          m_sv;
   logic [3:0]  m_sa;
   logic [7:0]  m_sd;
   bit          m_rstd;
   bit          m_eh, m_eo, m_et;
   int          m_xfer = 0;
   int          d_xfer = 0;

   task automatic model_reset();
      m_pend = 0; m_paddr = 0; m_since = 0; m_fifo.delete();
      m_sv = 0; m_sa = 0; m_sd = 0; m_rstd = 1;
      m_eh = 0; m_eo = 0; m_et = 0;
   endtask

   task automatic step(input bit rv, input logic [7:0] rd, input bit rdy, input bit clr, input bit rs);
      bit full_pre, pop, wr, hdr_e, ovf_e, tmo_e;
      logic [11:0] wv;
      @(negedge clk);
      check("c_valid", 32'(c_valid), 32'(m_sv));
      check("busy", 32'(busy), 32'(m_pend || (m_fifo.size() != 0) || m_sv));
      check("err_hdr", 32'(err_hdr), 32'(m_eh));
      check("err_ovf", 32'(err_ovf), 32'(m_eo));
      check("err_tmo", 32'(err_tmo), 32'(m_et));
      if (m_sv || m_rstd) begin
         check("c_addr", 32'(c_addr), 32'(m_sa));
         check("c_data", 32'(c_data), 32'(m_sd));
      end
      if (c_valid && rdy && rs) d_xfer++;
      rst = rs; rx_valid = rv; rx_data = rd; c_ready = rdy; err_clr = clr;
      if (!rs) begin
         model_reset();
      end else begin
         full_pre = (m_fifo.size() == DEPTH);
         pop = (m_fifo.size() != 0) && (!m_sv || rdy);
         wr = 0; hdr_e = 0; ovf_e = 0; tmo_e = 0; wv = '0;
         if (m_sv && rdy) m_xfer++;
         if (!m_pend) begin
            if (rv) begin
               if (rd[7:4] == 4'hA) begin
                  m_pend = 1; m_paddr = rd[3:0]; m_since = 0;
               end else begin
                  hdr_e = 1;
               end
            end
         end else if (rv) begin
            wr = 1; wv = {m_paddr, rd}; m_pend = 0;
         end else begin
            m_since++;
            if (m_since == TMO) begin
               tmo_e = 1; m_pend = 0;
            end
         end
         if (pop) begin
            {m_sa, m_sd} = m_fifo.pop_front();
            m_sv = 1; m_rstd = 0;
         end else if (m_sv && rdy) begin
            m_sv = 0;
         end
         if (wr) begin
            if (full_pre && !pop) ovf_e = 1;
            else m_fifo.push_back(wv);
         end
         m_eh = hdr_e || (m_eh && !clr);
         m_eo = ovf_e || (m_eo && !clr);
         m_et = tmo_e || (m_et && !clr);
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0, 1);
   endtask

   task automatic send(input logic [7:0] h, input logic [7:0] d, input bit rdy);
      step(1, h, rdy, 0, 1);
      step(1, d, rdy, 0, 1);
   endtask

   initial begin
      int gap;
      int rmode;
      bit rv, rdy;
      logic [7:0] b;
      model_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      step(0, 8'h00, 0, 0, 0);

      // Single write with the consumer ready.
      send(8'hA4, 8'h04, 1);
      idle(4, 1);

      // Long stall: write must hold steady until accepted once.
      send(8'hA8, 8'h02, 0);
      idle(78, 0);
      idle(3, 1);

      // Overflow: one in the output stage, DEPTH queued, the next dropped.
      for (int p = 0; p < 6; p++) send({4'hA, 4'(p + 1)}, 8'(8'h10 + p), 0);
      idle(2, 0);
      check("ovf_after_6", 32'(err_ovf), 32'd1);
      idle(8, 1);

      // Bad header, then clear.
      step(1, 8'h54, 1, 0, 1);
      idle(2, 1);
      step(0, 8'h00, 1, 1, 1);
      idle(2, 1);

      // Timeout, then the late data byte is parsed as a bad header.
      step(1, 8'hA4, 1, 0, 1);
      idle(TMO + 1, 1);
      step(1, 8'h03, 1, 0, 1);
      idle(2, 1);
      check("hdr_after_tmo", 32'(err_hdr), 32'd1);
      step(0, 8'h00, 1, 1, 1);

      // Reset during a stalled handshake with entries queued.
      for (int p = 0; p < 3; p++) send({4'hA, 4'(p + 9)}, 8'(8'hC0 + p), 0);
      idle(2, 0);
      step(0, 8'h00, 0, 0, 0);
      idle(5, 1);

      // Randomized traffic.
      gap = 0; rmode = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 50 == 0) rmode = $urandom_range(0, 2);
         if (gap > 0) begin
            gap--; rv = 0;
         end else begin
            rv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 30) == 0) gap = $urandom_range(1, 24);
         end
         b = ($urandom_range(0, 3) != 0) ? {4'hA, 4'($urandom)} : 8'($urandom);
         rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom);
         step(rv, b, rdy, ($urandom_range(0, 39) == 0), ($urandom_range(0, 499) != 0));
      end
      idle(20, 1);
      check("xfer_count", 32'(d_xfer), 32'(m_xfer));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
